quad_gen: RTL and testbench

QUAD_GEN -- requirements
Module: quad_gen

---
 rtl/quad_gen_pkg.sv | 18 +
 rtl/quad_step_timer.sv | 44 ++++
 rtl/quad_gen.sv | 119 +++++++++++
 tb/tb_quad_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/quad_gen_pkg.sv
// Shared definitions for the quadrature generator: controller state encoding
// and the 4-entry phase table that maps a phase index onto {quad_a, quad_b}.
package quad_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Walking the index upward yields A leading B; walking downward is the
    // exact reverse. Neighbouring entries differ in exactly one bit.
    localparam logic [1:0] PHASE_TABLE [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    function automatic logic [1:0] phase_ab(input logic [1:0] idx);
        return PHASE_TABLE[idx];
    endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Period down-counter for the quadrature generator.
// Ports:
//   clk_i      - clock
//   reset_i    - synchronous active-high reset
//   load_i     - latch period_i (0 is treated as 1) and start counting from it
//   period_i   - requested cycles between edges
//   en_i       - count down; reload from the latched period after reaching 1
//   clear_i    - force the counter to 0 (has priority over load and count)
//   tick_o     - high while the counter holds 1 (an edge is due this cycle)
module quad_step_timer #(
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    load_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    input  logic                    en_i,
    input  logic                    clear_i,
    output logic                    tick_o
);

    logic [PERIOD_WIDTH-1:0] count_q;
    logic [PERIOD_WIDTH-1:0] reload_q;
    logic [PERIOD_WIDTH-1:0] period_eff;

    assign period_eff = (period_i == '0) ? PERIOD_WIDTH'(1) : period_i;
    assign tick_o     = (count_q == PERIOD_WIDTH'(1));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= '0;
            reload_q <= '0;
        end else if (clear_i) begin
            count_q  <= '0;
        end else if (load_i) begin
            count_q  <= period_eff;
            reload_q <= period_eff;
        end else if (en_i) begin
            if (tick_o) count_q <= reload_q;
            else        count_q <= count_q - PERIOD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/quad_gen.sv
// Quadrature pulse generator. Accepts a signed step command and emits that
// many quadrature edges on quad_a/quad_b, one every period_eff clocks, while
// tracking a signed running position.
// Ports:
//   hba_clk, hba_reset        - clock, synchronous active-high reset
//   cmd_valid/cmd_ready       - command handshake
//   cmd_steps                 - signed edge count (negative = reverse)
//   cmd_period                - cycles between edges (0 behaves as 1)
//   abort                     - stop a running command without another edge
//   quad_a, quad_b            - quadrature outputs
//   busy, done, aborted       - status; done/aborted are one-cycle pulses
//   position                  - signed running edge count, wraps
module quad_gen
    import quad_gen_pkg::*;
#(
    parameter int STEP_WIDTH   = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    hba_clk,
    input  logic                    hba_reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [STEP_WIDTH-1:0]   cmd_steps,
    input  logic [PERIOD_WIDTH-1:0] cmd_period,
    input  logic                    abort,
    output logic                    quad_a,
    output logic                    quad_b,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [STEP_WIDTH-1:0]   position
);

    state_e                  state_q;
    logic [1:0]              phase_q, phase_d;
    logic [1:0]              ab_q;
    logic [STEP_WIDTH-1:0]   position_q, position_d;
    logic [STEP_WIDTH-1:0]   remaining_q;
    logic                    reverse_q;
    logic                    done_q, aborted_q;

    logic                    running, tick, step_edge, last_edge, accept_run;
    logic                    steps_neg;
    logic [STEP_WIDTH-1:0]   steps_mag;

    assign running    = (state_q == ST_RUN);
    assign steps_neg  = cmd_steps[STEP_WIDTH-1];
    // Magnitude kept unsigned so the most negative command still yields
    // 2^(STEP_WIDTH-1) edges.
    assign steps_mag  = steps_neg ? ({STEP_WIDTH{1'b0}} - cmd_steps) : cmd_steps;
    assign accept_run = !running && cmd_valid && (cmd_steps != '0);
    assign step_edge  = running && !abort && tick;
    assign last_edge  = step_edge && (remaining_q == STEP_WIDTH'(1));

    assign phase_d    = reverse_q ? (phase_q - 2'd1) : (phase_q + 2'd1);
    assign position_d = reverse_q ? (position_q - STEP_WIDTH'(1))
                                  : (position_q + STEP_WIDTH'(1));

    quad_step_timer #(
        .PERIOD_WIDTH(PERIOD_WIDTH)
    ) u_timer (
        .clk_i    (hba_clk),
        .reset_i  (hba_reset),
        .load_i   (accept_run),
        .period_i (cmd_period),
        .en_i     (running && !abort),
        .clear_i  (running && (abort || last_edge)),
        .tick_o   (tick)
    );

    always_ff @(posedge hba_clk) begin
        if (hba_reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= 2'd0;
            ab_q        <= 2'b00;
            position_q  <= '0;
            remaining_q <= '0;
            reverse_q   <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (!running) begin
                // abort is deliberately not looked at while idle
                if (cmd_valid) begin
                    if (cmd_steps == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        state_q     <= ST_RUN;
                        reverse_q   <= steps_neg;
                        remaining_q <= steps_mag;
                    end
                end
            end else if (abort) begin
                state_q   <= ST_IDLE;
                aborted_q <= 1'b1;
            end else if (tick) begin
                phase_q     <= phase_d;
                ab_q        <= phase_ab(phase_d);
                position_q  <= position_d;
                remaining_q <= remaining_q - STEP_WIDTH'(1);
                if (last_edge) begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready = !running;
    assign busy      = running;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign quad_a    = ab_q[1];
    assign quad_b    = ab_q[0];
    assign position  = position_q;

endmodule

// File: tb/tb_quad_gen.sv
module tb_quad_gen;

    logic        hba_clk = 1'b0;
    logic        hba_reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic [15:0] cmd_period;
    logic        abort;
    logic        quad_a, quad_b;
    logic        busy, done, aborted;
    logic [15:0] position;

    int total = 0;
    int bad   = 0;

    quad_gen #(.STEP_WIDTH(16), .PERIOD_WIDTH(16)) dut (
        .hba_clk    (hba_clk),
        .hba_reset  (hba_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_period (cmd_period),
        .abort      (abort),
        .quad_a     (quad_a),
        .quad_b     (quad_b),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .position   (position)
    );

    always #5 hba_clk = ~hba_clk;

    task automatic tick();
        @(posedge hba_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one command; returns just after the accepting edge.
    task automatic issue(input logic [15:0] s, input logic [15:0] p);
        cmd_valid  = 1'b1;
        cmd_steps  = s;
        cmd_period = p;
        tick();
        cmd_valid  = 1'b0;
        cmd_steps  = 16'h0;
        cmd_period = 16'h0;
    endtask

    function automatic logic [31:0] ab();
        return {30'd0, quad_a, quad_b};
    endfunction

    int exp_t1 [12] = '{0, 0, 2, 2, 2, 3, 3, 3, 1, 1, 1, 0};
    int n;
    int pulses;

    initial begin
        hba_reset  = 1'b1;
        cmd_valid  = 1'b0;
        cmd_steps  = 16'h0;
        cmd_period = 16'h0;
        abort      = 1'b0;
        tick();
        tick();
        hba_reset = 1'b0;
        tick();

        chk("rst_ab", ab(), 0);
        chk("rst_pos", position, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);

        // +4 steps, period 3; a command offered mid-run must be ignored
        issue(16'd4, 16'd3);
        chk("t1_busy", busy, 1);
        chk("t1_ready", cmd_ready, 0);
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) begin
                cmd_valid = 1'b1; cmd_steps = 16'd100; cmd_period = 16'd1;
            end
            tick();
            cmd_valid = 1'b0; cmd_steps = 16'h0; cmd_period = 16'h0;
            chk($sformatf("t1_ab_k%0d", k), ab(), exp_t1[k-1]);
            chk($sformatf("t1_done_k%0d", k), done, (k == 12) ? 1 : 0);
        end
        chk("t1_pos", position, 4);
        chk("t1_ready_at_done", cmd_ready, 1);
        chk("t1_busy_end", busy, 0);

        // -2 steps, period 1, straight after
        issue(16'hFFFE, 16'd1);
        tick();
        chk("t2_ab_e1", ab(), 1);
        chk("t2_done_e1", done, 0);
        tick();
        chk("t2_ab_e2", ab(), 3);
        chk("t2_done_e2", done, 1);
        chk("t2_pos", position, 2);
        tick();
        chk("t2_done_after", done, 0);

        // zero steps
        issue(16'd0, 16'd7);
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_ab", ab(), 3);
        tick();
        chk("t3_done_clr", done, 0);
        chk("t3_ab2", ab(), 3);
        chk("t3_pos", position, 2);

        // +10 steps, period 5, abort at cycle 12
        issue(16'd10, 16'd5);
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 12) abort = 1'b1;
            tick();
            if (done === 1'b1) pulses++;
            chk($sformatf("t4_ab_k%0d", k), ab(), (k < 5) ? 3 : (k < 10) ? 1 : 0);
            chk($sformatf("t4_aborted_k%0d", k), aborted, (k == 12) ? 1 : 0);
        end
        abort = 1'b0;
        chk("t4_ready", cmd_ready, 1);
        chk("t4_busy", busy, 0);
        chk("t4_pos", position, 4);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1) pulses++;
            chk($sformatf("t4_aborted_post%0d", k), aborted, 0);
            chk($sformatf("t4_ab_post%0d", k), ab(), 0);
        end
        chk("t4_no_done", pulses, 0);

        // period 0 with +3; abort alongside the accept is ignored in IDLE
        abort = 1'b1;
        issue(16'd3, 16'd0);
        abort = 1'b0;
        chk("t5_busy", busy, 1);
        tick();
        chk("t5_ab_e1", ab(), 2);
        tick();
        chk("t5_ab_e2", ab(), 3);
        chk("t5_done_e2", done, 0);
        tick();
        chk("t5_ab_e3", ab(), 1);
        chk("t5_done_e3", done, 1);
        chk("t5_pos", position, 7);

        // most negative step count, then walk across the 0x7FFF/0x8000 wrap
        hba_reset = 1'b1;
        tick();
        hba_reset = 1'b0;
        chk("t6_rst_pos", position, 0);
        chk("t6_rst_ab", ab(), 0);
        issue(16'h8000, 16'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 40000);
        chk("t6_neg_full_len", n, 32768);
        chk("t6_neg_full_pos", position, 32'h8000);
        chk("t6_neg_full_ab", ab(), 0);
        issue(16'hFFFF, 16'd1);
        tick();
        chk("t6_pos_7fff", position, 32'h7FFF);
        chk("t6_ab_7fff", ab(), 1);
        issue(16'd1, 16'd1);
        tick();
        chk("t6_pos_wrap", position, 32'h8000);
        chk("t6_done_wrap", done, 1);

        // reset mid-run beats abort and a new command
        issue(16'd5, 16'd4);
        for (int k = 1; k <= 6; k++) tick();
        chk("t7_ab_mid", ab(), 2);
        chk("t7_pos_mid", position, 32'h8001);
        hba_reset = 1'b1;
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_steps = 16'd3;
        tick();
        chk("t7_ab", ab(), 0);
        chk("t7_pos", position, 0);
        chk("t7_busy", busy, 0);
        chk("t7_ready", cmd_ready, 1);
        chk("t7_done", done, 0);
        chk("t7_aborted", aborted, 0);
        hba_reset = 1'b0;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        cmd_steps = 16'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("t7_quiet_done%0d", k), done, 0);
            chk($sformatf("t7_quiet_aborted%0d", k), aborted, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
